// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the MIPS bus arbiter
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, ERROR} arb_state_t;
  localparam logic [3:0] BYTEEN_ALL = 4'b1111;
  localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/mips_bus_watchdog.sv
// mips_bus_watchdog: saturating waitrequest counter with expiry detect
module mips_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] count;
  // expiry is flagged on the wait cycle whose increment reaches the limit
  assign expired = enable && count == LAST;
  // count wait cycles, restart on each grant, never wrap past the limit
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (enable && count != LIMIT) count <= count + 1'b1;
endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: arbitrates fetch and data ports onto one Avalon master
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error
);
  arb_state_t state;
  logic last_d;
  logic i_elig, d_elig, pick_d, pick_i, granted, expired;
  // a port whose ready is high this cycle has just been served and is skipped
  assign i_elig = i_req && !i_ready;
  assign d_elig = d_req && !d_ready;
  assign pick_d = d_elig && (!i_elig || !last_d);
  assign pick_i = i_elig && !pick_d;
  assign granted = state == GRANT_I || state == GRANT_D;
  mips_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .enable(granted && waitrequest),
    .expired(expired)
  );
  // arbitration FSM with registered Avalon command and port responses
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      last_d <= 1'b0;
      address <= '0;
      read <= 1'b0;
      write <= 1'b0;
      writedata <= '0;
      byteenable <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      bus_error <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE:
          if (pick_d) begin
            state <= GRANT_D;
            last_d <= 1'b1;
            address <= d_addr;
            read <= !d_write;
            write <= d_write;
            writedata <= d_wdata;
            byteenable <= d_byteenable;
          end else if (pick_i) begin
            state <= GRANT_I;
            last_d <= 1'b0;
            address <= i_addr;
            read <= 1'b1;
            write <= 1'b0;
            writedata <= '0;
            byteenable <= BYTEEN_ALL;
          end
        GRANT_I, GRANT_D:
          if (!waitrequest) begin
            state <= IDLE;
            read <= 1'b0;
            write <= 1'b0;
            if (state == GRANT_I) begin
              i_rdata <= readdata;
              i_ready <= 1'b1;
            end else begin
              if (read) d_rdata <= readdata;
              d_ready <= 1'b1;
            end
          end else if (expired) begin
            state <= ERROR;
            read <= 1'b0;
            write <= 1'b0;
            bus_error <= 1'b1;
          end
        default: begin
          read <= 1'b0;
          write <= 1'b0;
          bus_error <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed self-checking bench for mips_bus_arbiter
module tb_mips_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic i_req, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic d_req, d_write, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0] d_byteenable, byteenable;
  logic [31:0] address, writedata, readdata;
  logic read, write, waitrequest, bus_error;
  int checks = 0;
  int errors = 0;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ready(d_ready), .d_rdata(d_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; i_req = 0; d_req = 0; d_write = 0; i_addr = 32'h12345678;
    d_addr = 32'h9abcdef0; d_wdata = 32'h55aa55aa; d_byteenable = 4'b1010;
    waitrequest = 0; readdata = 32'hffffffff;
    step; step;
    checks++;
    if ({address, read, write, writedata, byteenable, i_ready, d_ready, i_rdata, d_rdata, bus_error} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%h rd=%b wr=%b wd=%h be=%b ir=%b dr=%b irdata=%h drdata=%h err=%b, all required 0",
               address, read, write, writedata, byteenable, i_ready, d_ready, i_rdata, d_rdata, bus_error);
    end
    reset = 1'b0;
    step;
    checks++;
    if (read !== 0 || write !== 0) begin errors++; $display("FAIL idle_after_reset: rd=%b wr=%b required 0 0", read, write); end
  endtask

  task automatic test_contention;
    i_addr = 32'h00400000; d_addr = 32'h10010000; d_write = 0; d_byteenable = 4'b1111;
    readdata = 32'h11112222; i_req = 1; d_req = 1;
    step;
    checks++;
    if (address !== 32'h10010000 || read !== 1 || write !== 0) begin errors++; $display("FAIL first_contention_data: addr=%h rd=%b wr=%b required 10010000 1 0", address, read, write); end
    step;
    checks++;
    if (d_ready !== 1 || i_ready !== 0 || d_rdata !== 32'h11112222 || read !== 0) begin errors++; $display("FAIL data_read_done: dr=%b ir=%b drdata=%h rd=%b required 1 0 11112222 0", d_ready, i_ready, d_rdata, read); end
    d_req = 0; readdata = 32'h33334444;
    step;
    checks++;
    if (address !== 32'h00400000 || read !== 1 || byteenable !== 4'b1111) begin errors++; $display("FAIL fetch_after_data: addr=%h rd=%b be=%b required 00400000 1 1111", address, read, byteenable); end
    step;
    checks++;
    if (i_ready !== 1 || i_rdata !== 32'h33334444) begin errors++; $display("FAIL fetch_done: ir=%b irdata=%h required 1 33334444", i_ready, i_rdata); end
    i_req = 0;
    step;
    i_req = 1; d_req = 1; readdata = 32'h55556666;
    step;
    checks++;
    if (address !== 32'h10010000 || read !== 1) begin errors++; $display("FAIL second_contention_data: addr=%h rd=%b required 10010000 1", address, read); end
    step;
    checks++;
    if (d_ready !== 1 || d_rdata !== 32'h55556666) begin errors++; $display("FAIL second_data_done: dr=%b drdata=%h required 1 55556666", d_ready, d_rdata); end
    i_req = 0; d_req = 0;
    step;
    i_req = 1; d_req = 1; readdata = 32'h77778888;
    step;
    checks++;
    if (address !== 32'h00400000 || read !== 1) begin errors++; $display("FAIL third_contention_fetch: addr=%h rd=%b required 00400000 1", address, read); end
    step;
    checks++;
    if (i_ready !== 1 || d_ready !== 0 || i_rdata !== 32'h77778888) begin errors++; $display("FAIL third_fetch_done: ir=%b dr=%b irdata=%h required 1 0 77778888", i_ready, d_ready, i_rdata); end
    i_req = 0; d_req = 0;
    step;
  endtask

  task automatic test_fetch;
    i_addr = 32'hBFC00000; readdata = 32'h24020005; i_req = 1;
    step;
    checks++;
    if (read !== 1 || write !== 0 || address !== 32'hBFC00000 || byteenable !== 4'b1111 || writedata !== 0 || i_ready !== 0) begin
      errors++; $display("FAIL fetch_cmd: rd=%b wr=%b addr=%h be=%b wd=%h ir=%b required 1 0 bfc00000 1111 0 0", read, write, address, byteenable, writedata, i_ready);
    end
    step;
    checks++;
    if (i_ready !== 1 || i_rdata !== 32'h24020005 || read !== 0) begin errors++; $display("FAIL fetch_ready: ir=%b irdata=%h rd=%b required 1 24020005 0", i_ready, i_rdata, read); end
    i_req = 0;
    step;
    checks++;
    if (i_ready !== 0) begin errors++; $display("FAIL fetch_pulse_width: ir=%b required 0", i_ready); end
  endtask

  task automatic test_write_wait;
    d_write = 1; d_addr = 32'h00001000; d_wdata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    waitrequest = 1; readdata = 32'hFFFFFFFF; d_req = 1;
    for (int k = 0; k < 4; k++) begin
      step;
      checks++;
      if (write !== 1 || read !== 0 || address !== 32'h00001000 || writedata !== 32'hDEADBEEF || byteenable !== 4'b0011 || d_ready !== 0) begin
        errors++; $display("FAIL write_cmd_%0d: wr=%b rd=%b addr=%h wd=%h be=%b dr=%b required 1 0 00001000 deadbeef 0011 0", k, write, read, address, writedata, byteenable, d_ready);
      end
      if (k == 3) waitrequest = 0;
    end
    step;
    checks++;
    if (d_ready !== 1 || write !== 0 || d_rdata !== 32'h55556666) begin errors++; $display("FAIL write_done: dr=%b wr=%b drdata=%h required 1 0 55556666", d_ready, write, d_rdata); end
    d_req = 0;
    step;
    checks++;
    if (d_ready !== 0) begin errors++; $display("FAIL write_pulse_width: dr=%b required 0", d_ready); end
  endtask

  task automatic test_timeout;
    i_addr = 32'h00400020; waitrequest = 1; i_req = 1;
    for (int k = 1; k <= 8; k++) begin
      step;
      checks++;
      if (read !== 1 || bus_error !== 0) begin errors++; $display("FAIL timeout_wait_%0d: rd=%b err=%b required 1 0", k, read, bus_error); end
    end
    step;
    checks++;
    if (bus_error !== 1 || read !== 0) begin errors++; $display("FAIL timeout_error: err=%b rd=%b required 1 0", bus_error, read); end
    i_req = 0; waitrequest = 0; d_req = 1; d_write = 1;
    for (int k = 0; k < 4; k++) begin
      step;
      checks++;
      if (d_ready !== 0 || i_ready !== 0 || read !== 0 || write !== 0 || bus_error !== 1) begin
        errors++; $display("FAIL error_ignores_req_%0d: dr=%b ir=%b rd=%b wr=%b err=%b required 0 0 0 0 1", k, d_ready, i_ready, read, write, bus_error);
      end
    end
    d_req = 0; d_write = 0;
  endtask

  task automatic test_reset_mid;
    reset = 1;
    step;
    reset = 0;
    checks++;
    if (bus_error !== 0) begin errors++; $display("FAIL reset_clears_error: err=%b required 0", bus_error); end
    i_addr = 32'h00400010; waitrequest = 1; i_req = 1;
    step;
    step;
    checks++;
    if (read !== 1) begin errors++; $display("FAIL waited_read_cmd: rd=%b required 1", read); end
    reset = 1; waitrequest = 0; readdata = 32'h0BADF00D;
    step;
    checks++;
    if (read !== 0 || i_ready !== 0 || bus_error !== 0 || i_rdata !== 0) begin
      errors++; $display("FAIL reset_abandons: rd=%b ir=%b err=%b irdata=%h required 0 0 0 0", read, i_ready, bus_error, i_rdata);
    end
    reset = 0; readdata = 32'hCAFEF00D;
    step;
    checks++;
    if (read !== 1 || address !== 32'h00400010) begin errors++; $display("FAIL refetch_cmd: rd=%b addr=%h required 1 00400010", read, address); end
    step;
    checks++;
    if (i_ready !== 1 || i_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL refetch_done: ir=%b irdata=%h required 1 cafef00d", i_ready, i_rdata); end
    i_req = 0;
    step;
  endtask

  initial begin
    test_reset;
    test_contention;
    test_fetch;
    test_write_wait;
    test_timeout;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
